// File: rtl/rgmii_rx_byte_assembler.sv
// RGMII receive byte assembler: turns DDR-captured RXD/RX_CTL halves into a
// byte stream with dv/er qualifiers, pairing nibbles in 10/100 mode.
module rgmii_rx_byte_assembler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NIBBLE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NIBBLE_WIDTH-1:0] rgmii_rxd_h,
  input  logic [NIBBLE_WIDTH-1:0] rgmii_rxd_l,
  input  logic                    rgmii_rx_ctl_h,
  input  logic                    rgmii_rx_ctl_l,
  input  logic                    mii_select,
  output logic [DATA_WIDTH-1:0]   rgmii_mac_rx_data,
  output logic                    rgmii_mac_rx_dv,
  output logic                    rgmii_mac_rx_er,
  output logic                    rx_frame_active
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GIG    = 2'd1,
    ST_MII_LO = 2'd2,
    ST_MII_HI = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   w_data_nxt;
  logic                    r_dv;
  logic                    w_dv_nxt;
  logic                    r_er;
  logic                    w_er_nxt;
  logic                    r_active;
  logic [NIBBLE_WIDTH-1:0] r_low;
  logic [NIBBLE_WIDTH-1:0] w_low_nxt;
  logic                    r_low_er;
  logic                    w_low_er_nxt;
  logic                    r_dv_prev;
  logic                    w_dv_in;
  logic                    w_er_in;
  logic                    w_start;

  assign w_dv_in = rgmii_rx_ctl_h;
  assign w_er_in = rgmii_rx_ctl_h ^ rgmii_rx_ctl_l;
  // A frame starts only on a rising dv_in; r_dv_prev resets high so a frame
  // already in flight at reset release is skipped.
  assign w_start = w_dv_in & ~r_dv_prev;

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_dv_nxt     = 1'b0;
    w_er_nxt     = 1'b0;
    w_low_nxt    = r_low;
    w_low_er_nxt = r_low_er;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (mii_select) begin
            w_low_nxt    = rgmii_rxd_h;
            w_low_er_nxt = w_er_in;
            w_state_nxt  = ST_MII_HI;
          end else begin
            w_data_nxt  = {rgmii_rxd_l, rgmii_rxd_h};
            w_dv_nxt    = 1'b1;
            w_er_nxt    = w_er_in;
            w_state_nxt = ST_GIG;
          end
        end
      end
      ST_GIG: begin
        if (w_dv_in) begin
          w_data_nxt = {rgmii_rxd_l, rgmii_rxd_h};
          w_dv_nxt   = 1'b1;
          w_er_nxt   = w_er_in;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MII_LO: begin
        if (w_dv_in) begin
          w_low_nxt    = rgmii_rxd_h;
          w_low_er_nxt = w_er_in;
          w_state_nxt  = ST_MII_HI;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MII_HI: begin
        w_dv_nxt = 1'b1;
        if (w_dv_in) begin
          w_data_nxt  = {rgmii_rxd_h, r_low};
          w_er_nxt    = w_er_in | r_low_er;
          w_state_nxt = ST_MII_LO;
        end else begin
          // Odd nibble count: flush the orphan low nibble flagged as errored.
          w_data_nxt  = {NIBBLE_WIDTH'(0), r_low};
          w_er_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_er      <= 1'b0;
      r_active  <= 1'b0;
      r_low     <= '0;
      r_low_er  <= 1'b0;
      r_dv_prev <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_dv      <= w_dv_nxt;
      r_er      <= w_er_nxt;
      r_active  <= (r_state != ST_IDLE);
      r_low     <= w_low_nxt;
      r_low_er  <= w_low_er_nxt;
      r_dv_prev <= w_dv_in;
    end
  end

  assign rgmii_mac_rx_data = r_data;
  assign rgmii_mac_rx_dv   = r_dv;
  assign rgmii_mac_rx_er   = r_er;
  assign rx_frame_active   = r_active;

endmodule

// File: tb/tb_rgmii_rx_byte_assembler.sv
// Scoreboard bench: frames are turned into expected bytes at frame level,
// a negedge monitor pops and compares whenever the DUT qualifies a byte.
module tb_rgmii_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rgmii_rxd_h, rgmii_rxd_l;
  logic       rgmii_rx_ctl_h, rgmii_rx_ctl_l, mii_select;
  logic [7:0] rgmii_mac_rx_data;
  logic       rgmii_mac_rx_dv, rgmii_mac_rx_er, rx_frame_active;

  rgmii_rx_byte_assembler dut (
    .clk              (clk),
    .reset            (reset),
    .rgmii_rxd_h      (rgmii_rxd_h),
    .rgmii_rxd_l      (rgmii_rxd_l),
    .rgmii_rx_ctl_h   (rgmii_rx_ctl_h),
    .rgmii_rx_ctl_l   (rgmii_rx_ctl_l),
    .mii_select       (mii_select),
    .rgmii_mac_rx_data(rgmii_mac_rx_data),
    .rgmii_mac_rx_dv  (rgmii_mac_rx_dv),
    .rgmii_mac_rx_er  (rgmii_mac_rx_er),
    .rx_frame_active  (rx_frame_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [3:0] l;
    logic       cl;
  } cyc_t;

  cyc_t       fr[$];
  logic [8:0] exp_q[$];   // {er, data}
  int         checks = 0;
  int         errors = 0;
  bit         cur_acc = 1'b0;
  bit         acc_d1, acc_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // cycles of dv_in that belong to an accepted frame, delayed to predict frame_active
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_d1 <= 1'b0;
      acc_d2 <= 1'b0;
    end else begin
      acc_d1 <= cur_acc;
      acc_d2 <= acc_d1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rgmii_mac_rx_dv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(rgmii_mac_rx_data), 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("rx_data", 32'(rgmii_mac_rx_data), 32'(e[7:0]));
          chk("rx_er", 32'(rgmii_mac_rx_er), 32'(e[8]));
        end
      end else begin
        chk("er_without_dv", 32'(rgmii_mac_rx_er), 32'd0);
      end
      chk("frame_active", 32'(rx_frame_active), 32'(acc_d2));
    end
  end

  task automatic drive(input logic [3:0] h, input logic [3:0] l, input logic ch,
                       input logic cl, input logic sel, input bit acc);
    @(posedge clk);
    #1;
    rgmii_rxd_h    = h;
    rgmii_rxd_l    = l;
    rgmii_rx_ctl_h = ch;
    rgmii_rx_ctl_l = cl;
    mii_select     = sel;
    cur_acc        = acc;
  endtask

  task automatic idle_cyc(input logic cl);
    drive(4'($urandom), 4'($urandom), 1'b0, cl, 1'($urandom), 1'b0);
  endtask

  // Expected bytes come straight from the frame contents and the mode it began in.
  task automatic send_frame(input logic mode, input bit rnd_sel);
    if (!mode) begin
      foreach (fr[i]) exp_q.push_back({!fr[i].cl, fr[i].l, fr[i].h});
    end else begin
      for (int i = 0; i < fr.size(); i += 2) begin
        if (i + 1 < fr.size())
          exp_q.push_back({(!fr[i].cl) | (!fr[i+1].cl), fr[i+1].h, fr[i].h});
        else
          exp_q.push_back({1'b1, 4'h0, fr[i].h});
      end
    end
    foreach (fr[i])
      drive(fr[i].h, fr[i].l, 1'b1, fr[i].cl,
            (i == 0) ? mode : (rnd_sel ? 1'($urandom) : !mode), 1'b1);
    idle_cyc(1'b0);
    fr.delete();
  endtask

  task automatic add(input logic [3:0] h, input logic [3:0] l, input logic cl);
    cyc_t c;
    c.h = h; c.l = l; c.cl = cl;
    fr.push_back(c);
  endtask

  initial begin
    reset = 1'b1;
    rgmii_rxd_h = '0; rgmii_rxd_l = '0;
    rgmii_rx_ctl_h = 1'b0; rgmii_rx_ctl_l = 1'b0; mii_select = 1'b0;
    #12;
    chk("reset_data", 32'(rgmii_mac_rx_data), 32'd0);
    chk("reset_dv", 32'(rgmii_mac_rx_dv), 32'd0);
    chk("reset_er", 32'(rgmii_mac_rx_er), 32'd0);
    chk("reset_active", 32'(rx_frame_active), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    idle_cyc(1'b0); idle_cyc(1'b0);

    // gigabit preamble, SFD, then 0xAB
    for (int i = 0; i < 7; i++) add(4'h5, 4'h5, 1'b1);
    add(4'h5, 4'hD, 1'b1);
    add(4'hB, 4'hA, 1'b1);
    send_frame(1'b0, 1'b0);
    idle_cyc(1'b0);

    // MII preamble 5 x15, D, then 4, 3
    for (int i = 0; i < 15; i++) add(4'h5, 4'($urandom), 1'b1);
    add(4'hD, 4'($urandom), 1'b1);
    add(4'h4, 4'($urandom), 1'b1);
    add(4'h3, 4'($urandom), 1'b1);
    send_frame(1'b1, 1'b1);
    idle_cyc(1'b1);

    // MII error in a low nibble, next byte clean
    add(4'h1, 4'h0, 1'b0); add(4'h2, 4'h0, 1'b1);
    add(4'h3, 4'h0, 1'b1); add(4'h4, 4'h0, 1'b1);
    send_frame(1'b1, 1'b1);

    // odd nibble count
    for (int i = 0; i < 4; i++) add(4'h5, 4'h0, 1'b1);
    add(4'h7, 4'h0, 1'b1);
    send_frame(1'b1, 1'b1);

    // mode switch mid gigabit frame, then an MII frame
    for (int i = 0; i < 6; i++) add(4'($urandom), 4'($urandom), 1'b1);
    send_frame(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(4'($urandom), 4'($urandom), 1'b1);
    send_frame(1'b1, 1'b0);

    // randomized frames with random gaps, false carrier and errors
    for (int f = 0; f < 40; f++) begin
      int len;
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++)
        add(4'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0));
      send_frame(1'($urandom), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) idle_cyc(1'($urandom));
    end

    // async reset between low and high nibble of an MII byte
    idle_cyc(1'b0);
    exp_q.push_back({1'b0, 8'h55});
    drive(4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #2;
    cur_acc = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset_data", 32'(rgmii_mac_rx_data), 32'd0);
    chk("midreset_dv", 32'(rgmii_mac_rx_dv), 32'd0);
    chk("midreset_er", 32'(rgmii_mac_rx_er), 32'd0);
    chk("midreset_active", 32'(rx_frame_active), 32'd0);
    drive(4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_cyc(1'b0);
    add(4'h5, 4'h0, 1'b1); add(4'h5, 4'h0, 1'b1);
    add(4'h5, 4'h0, 1'b1); add(4'hD, 4'h0, 1'b1);
    send_frame(1'b1, 1'b1);

    // false carrier in IDLE
    for (int i = 0; i < 4; i++) idle_cyc(1'b1);
    idle_cyc(1'b0); idle_cyc(1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
